// File: rtl/dram_rw_responder_if.sv
// rtl/dram_rw_responder_if.sv - request and backend signal bundle for dram_rw_responder
// Signals:
//   mem_addr, mem_read_en, mem_write_en, mem_byte_enable, mem_write_data  initiator -> responder
//   ack, read_data, busy, protocol_error                                   responder -> initiator
//   be_req, be_we, be_addr, be_wdata, be_wmask                             responder -> backend
//   be_ready, be_rvalid, be_rdata                                          backend -> responder
// Modports: slave (responder view), master (initiator/backend view).
`ifndef MEM_ADDR_BITS
`define MEM_ADDR_BITS 16
`endif

interface dram_rw_responder_if #(
    parameter int MEM_ADDR_BITS = `MEM_ADDR_BITS
);
    logic [MEM_ADDR_BITS-1:0] mem_addr;
    logic                     mem_read_en;
    logic                     mem_write_en;
    logic [3:0]               mem_byte_enable;
    logic [31:0]              mem_write_data;
    logic                     ack;
    logic [31:0]              read_data;
    logic                     busy;
    logic                     protocol_error;
    logic                     be_req;
    logic                     be_we;
    logic [MEM_ADDR_BITS:0]   be_addr;
    logic [15:0]              be_wdata;
    logic [1:0]               be_wmask;
    logic                     be_ready;
    logic                     be_rvalid;
    logic [15:0]              be_rdata;

    modport slave (
        input  mem_addr, mem_read_en, mem_write_en, mem_byte_enable, mem_write_data,
        input  be_ready, be_rvalid, be_rdata,
        output ack, read_data, busy, protocol_error,
        output be_req, be_we, be_addr, be_wdata, be_wmask
    );

    modport master (
        output mem_addr, mem_read_en, mem_write_en, mem_byte_enable, mem_write_data,
        output be_ready, be_rvalid, be_rdata,
        input  ack, read_data, busy, protocol_error,
        input  be_req, be_we, be_addr, be_wdata, be_wmask
    );
endinterface

// File: rtl/dram_rw_responder.sv
// rtl/dram_rw_responder.sv - DRAM request endpoint executing word accesses as half-word backend transactions
// Ports:
//   clk      clock
//   reset_n  asynchronous active-low reset
//   bus      dram_rw_responder_if.slave: word strobes in, ack/read_data/busy/protocol_error out,
//            16-bit backend request/response port
`ifndef MEM_ADDR_BITS
`define MEM_ADDR_BITS 16
`endif

module dram_rw_responder #(
    parameter int MEM_ADDR_BITS = `MEM_ADDR_BITS,
    parameter int XLEN          = 32
) (
    input logic                clk,
    input logic                reset_n,
    dram_rw_responder_if.slave bus
);
    localparam int HALF = XLEN / 2;

    typedef enum logic [5:0] {
        IDLE    = 6'b000001,
        REQ_LO  = 6'b000010,
        WAIT_LO = 6'b000100,
        REQ_HI  = 6'b001000,
        WAIT_HI = 6'b010000,
        ACK     = 6'b100000
    } state_t;

    state_t                   state_q, state_d;
    logic [MEM_ADDR_BITS-1:0] addr_q, addr_d;
    logic                     we_q, we_d;
    logic [XLEN-1:0]          wdata_q, wdata_d;
    logic [3:0]               be_q, be_d;
    logic [HALF-1:0]          lo_q, lo_d;
    logic [XLEN-1:0]          rdata_q, rdata_d;
    logic                     err_q, err_d;
    logic                     ack_q, busy_q, req_q, be_we_q;
    logic [MEM_ADDR_BITS:0]   be_addr_q;
    logic [HALF-1:0]          be_wdata_q;
    logic [1:0]               be_wmask_q;
    logic                     strobe, in_wait, hi_d;

    assign strobe  = bus.mem_read_en | bus.mem_write_en;
    assign in_wait = (state_q == WAIT_LO) || (state_q == WAIT_HI);
    assign hi_d    = (state_d == REQ_HI);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        lo_d    = lo_q;
        rdata_d = rdata_q;
        err_d   = err_q;

        // Error flags are sticky; none of them alters the access in flight.
        if (strobe && state_q != IDLE) err_d = 1'b1;
        if (bus.mem_read_en && bus.mem_write_en) err_d = 1'b1;
        if (bus.be_rvalid && !in_wait) err_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (strobe) begin
                    addr_d  = bus.mem_addr;
                    we_d    = bus.mem_write_en;
                    wdata_d = bus.mem_write_data;
                    be_d    = bus.mem_byte_enable;
                    // Writes skip halves with no enabled lanes; reads always fetch both.
                    if (!bus.mem_write_en)                       state_d = REQ_LO;
                    else if (bus.mem_byte_enable[1:0] != 2'b00)  state_d = REQ_LO;
                    else if (bus.mem_byte_enable[3:2] != 2'b00)  state_d = REQ_HI;
                    else                                         state_d = ACK;
                end
            end
            REQ_LO: begin
                if (bus.be_ready) begin
                    if (!we_q)                   state_d = WAIT_LO;
                    else if (be_q[3:2] != 2'b00) state_d = REQ_HI;
                    else                         state_d = ACK;
                end
            end
            WAIT_LO: begin
                if (bus.be_rvalid) begin
                    lo_d    = bus.be_rdata;
                    state_d = REQ_HI;
                end
            end
            REQ_HI: begin
                if (bus.be_ready) state_d = we_q ? ACK : WAIT_HI;
            end
            WAIT_HI: begin
                if (bus.be_rvalid) begin
                    rdata_d = {bus.be_rdata, lo_q};
                    state_d = ACK;
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next-state view so they line up with the state they describe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            be_q       <= '0;
            lo_q       <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            ack_q      <= 1'b0;
            busy_q     <= 1'b0;
            req_q      <= 1'b0;
            be_we_q    <= 1'b0;
            be_addr_q  <= '0;
            be_wdata_q <= '0;
            be_wmask_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            lo_q       <= lo_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
            ack_q      <= (state_d == ACK);
            busy_q     <= (state_d != IDLE);
            req_q      <= (state_d == REQ_LO) || (state_d == REQ_HI);
            be_we_q    <= we_d;
            be_addr_q  <= {addr_d, hi_d};
            be_wdata_q <= hi_d ? wdata_d[XLEN-1:HALF] : wdata_d[HALF-1:0];
            be_wmask_q <= hi_d ? be_d[3:2] : be_d[1:0];
        end
    end

    assign bus.ack            = ack_q;
    assign bus.read_data      = rdata_q;
    assign bus.busy           = busy_q;
    assign bus.protocol_error = err_q;
    assign bus.be_req         = req_q;
    assign bus.be_we          = be_we_q;
    assign bus.be_addr        = be_addr_q;
    assign bus.be_wdata       = be_wdata_q;
    assign bus.be_wmask       = be_wmask_q;
endmodule

// File: tb/tb_dram_rw_responder.sv
// tb/tb_dram_rw_responder.sv - scoreboard bench for dram_rw_responder
module tb_dram_rw_responder;
    localparam int AW = 16;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    dram_rw_responder_if #(.MEM_ADDR_BITS(AW)) bus ();
    dram_rw_responder #(.MEM_ADDR_BITS(AW)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    typedef struct { bit is_read; logic [31:0] data; int scyc; int lat; } sb_t;
    typedef struct { logic [AW:0] addr; bit we; logic [15:0] wdata; logic [1:0] mask; } tx_t;
    typedef struct { logic [15:0] data; int due; } rd_t;

    sb_t  sb_q[$];
    tx_t  tx_q[$];
    rd_t  pend_q[$];
    logic [31:0] ref_mem [int];
    logic [15:0] half_mem [int];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int exp_acks = 0;
    int acks_seen = 0;
    bit rand_ready = 0;
    int rv_delay_max = 0;
    int rv_fixed = 0;
    int stall_target = 0;
    int stall_used = 0;
    bit stray_req = 0;

    // process-local state kept at module scope
    bit          mon_prev_ack = 0;
    sb_t         mon_e;
    tx_t         be_t;
    logic [15:0] be_hv;
    int          be_k;
    bit          be_prev_stall = 0;
    logic [AW:0] be_prev_addr = '0;
    bit          op;
    bit          found;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every ack pops one expected completion.
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (!reset_n) mon_prev_ack = 0;
            else begin
                if (bus.ack) begin
                    chk("ack_gap", {31'b0, mon_prev_ack}, 32'h0);
                    checks++;
                    if (sb_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_ack: got ack with nothing outstanding, expected none");
                    end else begin
                        mon_e = sb_q.pop_front();
                        if (mon_e.lat >= 0) chk("ack_latency", cyc - mon_e.scyc, mon_e.lat);
                        if (mon_e.is_read) chk("read_data", bus.read_data, mon_e.data);
                    end
                    acks_seen++;
                end
                mon_prev_ack = bus.ack;
            end
        end
    end

    // Backend model: half-word memory, checks each accepted request, returns read data in order.
    initial begin : backend
        bus.be_ready  = 1'b1;
        bus.be_rvalid = 1'b0;
        bus.be_rdata  = 16'h0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                pend_q.delete();
                be_prev_stall = 0;
            end else begin
                if (be_prev_stall) begin
                    chk("stall_req_held", {31'b0, bus.be_req}, 32'h1);
                    chk("stall_addr_held", 32'(bus.be_addr), 32'(be_prev_addr));
                end
                be_prev_stall = bus.be_req && !bus.be_ready;
                be_prev_addr  = bus.be_addr;
                if (bus.be_req && bus.be_ready) begin
                    checks++;
                    if (tx_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_be_req: got be_addr %h, expected no request", bus.be_addr);
                    end else begin
                        be_t = tx_q.pop_front();
                        chk("be_addr", 32'(bus.be_addr), 32'(be_t.addr));
                        chk("be_we", {31'b0, bus.be_we}, {31'b0, be_t.we});
                        if (be_t.we) begin
                            chk("be_wdata", {16'h0, bus.be_wdata}, {16'h0, be_t.wdata});
                            chk("be_wmask", {30'h0, bus.be_wmask}, {30'h0, be_t.mask});
                        end
                    end
                    be_k  = int'(bus.be_addr);
                    be_hv = half_mem.exists(be_k) ? half_mem[be_k] : 16'h0;
                    if (bus.be_we) begin
                        if (bus.be_wmask[0]) be_hv[7:0]  = bus.be_wdata[7:0];
                        if (bus.be_wmask[1]) be_hv[15:8] = bus.be_wdata[15:8];
                        half_mem[be_k] = be_hv;
                    end else begin
                        pend_q.push_back('{data: be_hv,
                            due: cyc + 1 + rv_fixed + int'($urandom_range(rv_delay_max, 0))});
                    end
                end
            end
            @(posedge clk);
            #1;
            if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
                bus.be_rvalid = 1'b1;
                bus.be_rdata  = pend_q[0].data;
                void'(pend_q.pop_front());
            end else begin
                bus.be_rvalid = stray_req;
                bus.be_rdata  = 16'($urandom);
            end
            if (bus.be_req && stall_used < stall_target) begin
                bus.be_ready = 1'b0;
                stall_used++;
            end else begin
                bus.be_ready = rand_ready ? ($urandom_range(3, 0) != 0) : 1'b1;
            end
        end
    end

    // Issue one strobe and record the expected backend traffic and completion.
    task automatic issue(input bit rd, input bit wr, input logic [AW-1:0] a,
                         input logic [3:0] be, input logic [31:0] d, input int lat);
        sb_t e;
        logic [31:0] w;
        @(posedge clk);
        #1;
        bus.mem_addr        = a;
        bus.mem_read_en     = rd;
        bus.mem_write_en    = wr;
        bus.mem_byte_enable = be;
        bus.mem_write_data  = d;
        w = ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 32'h0;
        if (wr) begin
            for (int h = 0; h < 2; h++)
                if (be[2*h +: 2] != 2'b00)
                    tx_q.push_back('{addr: {a, 1'(h)}, we: 1'b1, wdata: d[16*h +: 16], mask: be[2*h +: 2]});
            for (int i = 0; i < 4; i++)
                if (be[i]) w[8*i +: 8] = d[8*i +: 8];
            ref_mem[int'(a)] = w;
            e = '{is_read: 1'b0, data: 32'h0, scyc: cyc, lat: lat};
        end else begin
            tx_q.push_back('{addr: {a, 1'b0}, we: 1'b0, wdata: 16'h0, mask: 2'b0});
            tx_q.push_back('{addr: {a, 1'b1}, we: 1'b0, wdata: 16'h0, mask: 2'b0});
            e = '{is_read: 1'b1, data: w, scyc: cyc, lat: lat};
        end
        sb_q.push_back(e);
        exp_acks++;
        @(posedge clk);
        #1;
        bus.mem_read_en  = 1'b0;
        bus.mem_write_en = 1'b0;
    endtask

    // A strobe the responder must ignore: nothing is expected from it.
    task automatic ignored_strobe(input bit rd, input bit wr, input logic [AW-1:0] a, input logic [31:0] d);
        @(posedge clk);
        #1;
        bus.mem_addr        = a;
        bus.mem_read_en     = rd;
        bus.mem_write_en    = wr;
        bus.mem_byte_enable = 4'hF;
        bus.mem_write_data  = d;
        @(posedge clk);
        #1;
        bus.mem_read_en  = 1'b0;
        bus.mem_write_en = 1'b0;
    endtask

    task automatic wait_acks();
        int n = 0;
        while (acks_seen != exp_acks && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (acks_seen != exp_acks) begin
            errors++;
            $display("FAIL ack_timeout: got %0d acks, expected %0d", acks_seen, exp_acks);
            exp_acks = acks_seen;
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        sb_q.delete();
        tx_q.delete();
        repeat (2) @(posedge clk);
        exp_acks = acks_seen;
        #1 reset_n = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ack"}, {31'b0, bus.ack}, 32'h0);
        chk({tag, "_read_data"}, bus.read_data, 32'h0);
        chk({tag, "_busy"}, {31'b0, bus.busy}, 32'h0);
        chk({tag, "_protocol_error"}, {31'b0, bus.protocol_error}, 32'h0);
        chk({tag, "_be_req"}, {31'b0, bus.be_req}, 32'h0);
        chk({tag, "_be_we"}, {31'b0, bus.be_we}, 32'h0);
        chk({tag, "_be_addr"}, 32'(bus.be_addr), 32'h0);
        chk({tag, "_be_wdata"}, {16'h0, bus.be_wdata}, 32'h0);
        chk({tag, "_be_wmask"}, {30'h0, bus.be_wmask}, 32'h0);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        bus.mem_addr        = '0;
        bus.mem_read_en     = 1'b0;
        bus.mem_write_en    = 1'b0;
        bus.mem_byte_enable = 4'h0;
        bus.mem_write_data  = 32'h0;
        repeat (3) @(posedge clk);
        #2;
        check_reset_outputs("reset");
        reset_n = 1'b1;

        // Full write, read back, read_data held through a later write
        issue(0, 1, 16'h10, 4'hF, 32'hDEADBEEF, 3);  wait_acks();
        issue(1, 0, 16'h10, 4'h0, 32'h0, 5);         wait_acks();
        issue(0, 1, 16'h22, 4'hF, 32'h12345678, 3);  wait_acks();
        chk("read_data_hold", bus.read_data, 32'hDEADBEEF);

        // Partial writes
        issue(0, 1, 16'h30, 4'hC, 32'hCAFE1111, 2);  wait_acks();
        issue(0, 1, 16'h31, 4'h0, 32'h55555555, 1);  wait_acks();
        issue(1, 0, 16'h30, 4'h0, 32'h0, 5);         wait_acks();

        // Backend stall of three cycles in the low request
        stall_target = stall_used + 3;
        issue(0, 1, 16'h40, 4'hF, 32'hA5A55A5A, 6);  wait_acks();

        // Randomized traffic with random ready and read-data delay
        rand_ready = 1;
        rv_delay_max = 2;
        for (int i = 0; i < 60; i++) begin
            op = ($urandom_range(1, 0) == 1);
            issue(op, !op, AW'(16'h40 + $urandom_range(7, 0)), 4'($urandom), $urandom, -1);
            wait_acks();
        end
        rand_ready = 0;
        rv_delay_max = 0;
        repeat (3) @(negedge clk);
        chk("no_error_normal_traffic", {31'b0, bus.protocol_error}, 32'h0);

        // Strobe while busy: only the first access completes
        do_reset();
        issue(1, 0, 16'h10, 4'h0, 32'h0, 5);
        ignored_strobe(0, 1, 16'h10, 32'h01020304);
        wait_acks();
        repeat (4) @(negedge clk);
        chk("err_strobe_busy", {31'b0, bus.protocol_error}, 32'h1);
        issue(1, 0, 16'h10, 4'h0, 32'h0, 5);         wait_acks();

        // Simultaneous read and write executes as a write
        do_reset();
        issue(1, 1, 16'h50, 4'hF, 32'h0BADF00D, 3);  wait_acks();
        repeat (2) @(negedge clk);
        chk("err_rd_wr", {31'b0, bus.protocol_error}, 32'h1);
        issue(1, 0, 16'h50, 4'h0, 32'h0, 5);         wait_acks();

        // Stray rvalid in IDLE
        do_reset();
        @(negedge clk);
        stray_req = 1;
        @(posedge clk);
        #2 stray_req = 0;
        @(posedge clk);
        @(negedge clk);
        chk("err_stray_rvalid", {31'b0, bus.protocol_error}, 32'h1);
        chk("stray_busy", {31'b0, bus.busy}, 32'h0);
        chk("stray_be_req", {31'b0, bus.be_req}, 32'h0);
        issue(1, 0, 16'h50, 4'h0, 32'h0, 5);         wait_acks();

        // Reset while waiting for the high half
        do_reset();
        rv_fixed = 4;
        issue(1, 0, 16'h10, 4'h0, 32'h0, -1);
        found = 0;
        for (int n = 0; n < 50 && !found; n++) begin
            @(negedge clk);
            if (bus.be_req && bus.be_ready && bus.be_addr[0] && !bus.be_we) found = 1;
        end
        chk("reached_wait_hi", {31'b0, found}, 32'h1);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1 check_reset_outputs("abort");
        do_reset();
        rv_fixed = 0;
        issue(1, 0, 16'h10, 4'h0, 32'h0, 5);         wait_acks();

        repeat (4) @(negedge clk);
        chk("scoreboard_drained", sb_q.size(), 0);
        chk("backend_drained", tx_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
